// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bundle plus the two decode-stage read ports of the register file.
// The pipeline side drives the master modport; the register file takes the slave modport.
interface wb_regfile_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]      WB_in;
  logic [4:0]      RD_in;
  logic [XLEN-1:0] MEM_in;
  logic [XLEN-1:0] ALU_in;
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic [31:0]     commit_cnt;

  modport master (
    output WB_in, RD_in, MEM_in, ALU_in, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, commit_cnt
  );

  modport slave (
    input  WB_in, RD_in, MEM_in, ALU_in, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, commit_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/MEM result, commits it to the GPR array and serves two
// combinational read ports with same-cycle write-to-read bypass. Counts committed writes.
module wb_regfile #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned XLEN     = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_regfile_if.slave   bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     cnt_q, cnt_d;

  logic [AW-1:0]   rd_idx, rs_idx, rt_idx;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic            rd_is_zero;

  assign rd_idx = bus.RD_in[AW-1:0];
  assign rs_idx = bus.rs_addr[AW-1:0];
  assign rt_idx = bus.rt_addr[AW-1:0];

  assign wb_data    = bus.WB_in[0] ? bus.MEM_in : bus.ALU_in;
  assign rd_is_zero = ZERO_REG && (rd_idx == '0);
  // rst_n gates the enable so nothing bypasses or commits while reset is held.
  assign wb_we      = bus.WB_in[1] && !rd_is_zero && rst_n;

  always_comb begin
    cnt_d = cnt_q;
    if (wb_we) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wb_we) begin
        regs_q[rd_idx] <= wb_data;
      end
      cnt_q <= cnt_d;
    end
  end

  // Priority: hardwired zero, then bypass of the write landing this cycle, then array.
  always_comb begin
    bus.rs_data = regs_q[rs_idx];
    if (wb_we && (rs_idx == rd_idx)) begin
      bus.rs_data = wb_data;
    end
    if (ZERO_REG && (rs_idx == '0)) begin
      bus.rs_data = '0;
    end
  end

  always_comb begin
    bus.rt_data = regs_q[rt_idx];
    if (wb_we && (rt_idx == rd_idx)) begin
      bus.rt_data = wb_data;
    end
    if (ZERO_REG && (rt_idx == '0)) begin
      bus.rt_data = '0;
    end
  end

  assign bus.wb_data    = wb_data;
  assign bus.wb_we      = wb_we;
  assign bus.commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector table plus hand sequences (mid-run reset, counter wrap) and a short
// random run against a reference array for wb_regfile.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_regfile_if #(.XLEN(32)) bus ();

  wb_regfile #(
    .NREG    (32),
    .XLEN    (32),
    .ZERO_REG(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] ers;
    logic [31:0] ert;
    logic [31:0] ewb;
    logic        ewe;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [4:0] rd, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rs, input logic [4:0] rt);
    bus.WB_in   = wb;
    bus.RD_in   = rd;
    bus.MEM_in  = mem;
    bus.ALU_in  = alu;
    bus.rs_addr = rs;
    bus.rt_addr = rt;
  endtask

  logic [31:0] m [32];
  logic [31:0] mcnt;
  logic [31:0] mwb;
  logic        mwe;
  logic [1:0]  rwb;
  logic [4:0]  rrd, rrs, rrt;
  logic [31:0] rmem, ralu;

  initial begin
    checks = 0;
    errors = 0;
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

    //           wb     rd    rs    rt    mem           alu           ers           ert           ewb           we    cnt
    vt[0]  = '{2'b10, 5'd3, 5'd3, 5'd0, 32'h55550002, 32'hAAAA0001, 32'hAAAA0001, 32'h0,        32'hAAAA0001, 1'b1, 32'd0};
    vt[1]  = '{2'b11, 5'd4, 5'd3, 5'd4, 32'h55550002, 32'hAAAA0001, 32'hAAAA0001, 32'h55550002, 32'h55550002, 1'b1, 32'd1};
    vt[2]  = '{2'b00, 5'd0, 5'd3, 5'd4, 32'h0,        32'h0,        32'hAAAA0001, 32'h55550002, 32'h0,        1'b0, 32'd2};
    vt[3]  = '{2'b10, 5'd7, 5'd7, 5'd7, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'd2};
    vt[4]  = '{2'b00, 5'd0, 5'd7, 5'd7, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 32'd3};
    vt[5]  = '{2'b11, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32'd3};
    vt[6]  = '{2'b01, 5'd9, 5'd9, 5'd0, 32'h12345678, 32'h0,        32'h0,        32'h0,        32'h12345678, 1'b0, 32'd3};
    vt[7]  = '{2'b00, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd3};
    vt[8]  = '{2'b10, 5'd2, 5'd2, 5'd9, 32'h0,        32'h1,        32'h1,        32'h0,        32'h1,        1'b1, 32'd3};
    vt[9]  = '{2'b10, 5'd2, 5'd2, 5'd9, 32'h0,        32'h2,        32'h2,        32'h0,        32'h2,        1'b1, 32'd4};
    vt[10] = '{2'b10, 5'd2, 5'd2, 5'd9, 32'h0,        32'h3,        32'h3,        32'h0,        32'h3,        1'b1, 32'd5};
    vt[11] = '{2'b00, 5'd0, 5'd2, 5'd3, 32'h0,        32'h0,        32'h3,        32'hAAAA0001, 32'h0,        1'b0, 32'd6};
    vt[12] = '{2'b10, 5'd5, 5'd5, 5'd5, 32'h0,        32'h1234,     32'h1234,     32'h1234,     32'h1234,     1'b1, 32'd6};
    vt[13] = '{2'b00, 5'd0, 5'd5, 5'd2, 32'h0,        32'h0,        32'h1234,     32'h3,        32'h0,        1'b0, 32'd7};

    // Power-on reset
    rst_n = 1'b0;
    #12;
    chk("reset_cnt", bus.commit_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      chk("reset_rs", bus.rs_data, 32'h0);
      chk("reset_rt", bus.rt_data, 32'h0);
    end

    // Directed table, each row occupies one cycle and is checked before its edge
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].wb, vt[i].rd, vt[i].mem, vt[i].alu, vt[i].rs, vt[i].rt);
      #1;
      chk($sformatf("vec%0d_rs", i), bus.rs_data, vt[i].ers);
      chk($sformatf("vec%0d_rt", i), bus.rt_data, vt[i].ert);
      chk($sformatf("vec%0d_wbdata", i), bus.wb_data, vt[i].ewb);
      chk($sformatf("vec%0d_we", i), {31'h0, bus.wb_we}, {31'h0, vt[i].ewe});
      chk($sformatf("vec%0d_cnt", i), bus.commit_cnt, vt[i].ecnt);
    end

    // Reset asserted mid-run with a write pending: array and counter clear immediately
    @(negedge clk);
    drive(2'b10, 5'd6, 32'h0, 32'h0000CAFE, 5'd5, 5'd6);
    #1;
    chk("pre_rst_rs", bus.rs_data, 32'h1234);
    chk("pre_rst_rt", bus.rt_data, 32'h0000CAFE);
    rst_n = 1'b0;
    #1;
    chk("in_rst_rs", bus.rs_data, 32'h0);
    chk("in_rst_rt", bus.rt_data, 32'h0);
    chk("in_rst_we", {31'h0, bus.wb_we}, 32'h0);
    chk("in_rst_cnt", bus.commit_cnt, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      chk("post_rst_rs", bus.rs_data, 32'h0);
      chk("post_rst_rt", bus.rt_data, 32'h0);
    end
    chk("post_rst_cnt", bus.commit_cnt, 32'h0);

    // Counter wrap: preload to all-ones, one more commit rolls to zero
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", bus.commit_cnt, 32'hFFFFFFFF);
    drive(2'b10, 5'd1, 32'h0, 32'h77, 5'd1, 5'd0);
    #1;
    chk("wrap_bypass", bus.rs_data, 32'h77);
    @(negedge clk);
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0);
    #1;
    chk("wrap_cnt", bus.commit_cnt, 32'h0);
    chk("wrap_r1", bus.rs_data, 32'h77);

    // Random run against a reference array, starting from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rwb  = 2'($urandom_range(0, 3));
      rrd  = 5'($urandom_range(0, 31));
      rrs  = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
      rrt  = ($urandom_range(0, 3) == 0) ? rrd : 5'($urandom_range(0, 31));
      rmem = $urandom;
      ralu = $urandom;
      drive(rwb, rrd, rmem, ralu, rrs, rrt);
      mwb = rwb[0] ? rmem : ralu;
      mwe = rwb[1] && (rrd != 5'd0);
      #1;
      chk("rnd_rs", bus.rs_data,
          (rrs == 5'd0) ? 32'h0 : ((mwe && rrs == rrd) ? mwb : m[rrs]));
      chk("rnd_rt", bus.rt_data,
          (rrt == 5'd0) ? 32'h0 : ((mwe && rrt == rrd) ? mwb : m[rrt]));
      chk("rnd_cnt", bus.commit_cnt, mcnt);
      if (mwe) begin
        m[rrd] = mwb;
        mcnt   = mcnt + 32'd1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
